alu_result_serializer: RTL and testbench
========================================

ALU_RESULT_SERIALIZER -- requirements
Module: alu_result_serializer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit; legal range 1..255.
REQ-002 Parameter PARITY_EN, default 1, meaning 1 inserts an even-parity bit, 0 omits it.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream ALU result is present.
REQ-006 in_ready  output  1  block can accept a result this cycle.
REQ-007 in_result  input  9  ALU result word, unsigned.
REQ-008 tx_out  output  1  serial line; idle level 1.
REQ-009 busy  output  1  a frame is being shifted out.
REQ-010 frame_cnt  output  8  count of completed frames; wraps 255->0.

Function
REQ-011 A transfer occurs on a rising edge where in_valid and in_ready are both 1; in_result is captured into a one-entry holding register.
REQ-012 in_ready SHALL equal NOT hold_valid, registered; no combinational path from in_valid to in_ready.
REQ-013 FSM states: IDLE, START, DATA, PARITY, STOP; busy = 1 in every state except IDLE.
REQ-014 IDLE with hold_valid=1: next edge loads shift register from the holding register, clears hold_valid, enters START.
REQ-015 START drives tx_out=0; DATA drives bits 0..8 LSB first; PARITY drives XOR of all 9 bits; STOP drives 1.
REQ-016 Each state holds one bit for exactly CLKS_PER_BIT cycles.
REQ-017 PARITY_EN=0: DATA goes directly to STOP.
REQ-018 Frame length: 12*CLKS_PER_BIT cycles with parity; 11*CLKS_PER_BIT cycles without.
REQ-019 Latency: the start bit appears on tx_out from the edge after the accepting edge, i.e. one cycle after the handshake.
REQ-020 At the end of STOP: frame_cnt increments; with hold_valid=1 the FSM goes directly to START with no idle cycle, otherwise to IDLE.
REQ-021 The holding register may be refilled during any non-IDLE state, giving one frame of buffering.
REQ-022 Holding-register load and FSM unload are never simultaneous, because in_ready=0 whenever hold_valid=1.
REQ-023 in_result is ignored when in_valid=0; X on in_result with in_valid=0 SHALL NOT propagate.
REQ-024 tx_out and busy SHALL be registered outputs, glitch-free.

Reset
REQ-025 Asserting reset (0), including mid-frame, immediately forces: state IDLE, tx_out=1, busy=0, in_ready=1, hold_valid=0, frame_cnt=0, bit counter 0, baud counter 0.
REQ-026 A frame truncated by reset is discarded and not counted.
REQ-027 After reset deasserts, the first transfer is accepted on the first rising edge.

Structure
REQ-028 The shared package alu_fifo_pkg holds the FSM state enum, RESULT_W=9, FRAME_CNT_W=8 and the default CLKS_PER_BIT.
REQ-029 Sub-module alu_bit_timer: a baud down-counter that produces a one-cycle bit_done pulse every CLKS_PER_BIT cycles while enabled, and restarts on load.
REQ-030 RTL size: 120-400 lines including alu_bit_timer.

Verification
REQ-031 Reset pulse mid-frame (in_result=9'h0A5 in flight) -> next cycle tx_out=1, busy=0, in_ready=1, frame_cnt=0.
REQ-032 Single transfer 9'h006, CLKS_PER_BIT=4, PARITY_EN=1 -> tx_out sequence 0,0,1,1,0,0,0,0,0,0,0,1, each bit held 4 cycles; busy for 48 cycles; frame_cnt=1.
REQ-033 Data 9'h1FF (odd parity) -> parity bit 1; with PARITY_EN=0 the frame is 44 cycles and has no parity bit.
REQ-034 Three back-to-back results 9'h006, 9'h004, 9'h008 with in_valid held high -> in_ready toggles per REQ-012; frames contiguous with no idle gap; frame_cnt=3.
REQ-035 In-flight stall: second result offered while hold_valid=1 -> in_ready=0 until the first frame ends; in_result held stable by upstream; no data lost or duplicated.
REQ-036 256 frames with CLKS_PER_BIT=1 -> frame_cnt wraps to 0; the scoreboard reconstructs every transmitted word and parity bit from tx_out.

Source files
------------

// File: rtl/alu_fifo_pkg.sv
// Shared sizes, state encoding and helpers for the ALU result serializer.
package alu_fifo_pkg;

  localparam int unsigned RESULT_W         = 9;
  localparam int unsigned FRAME_CNT_W      = 8;
  localparam int unsigned CLKS_PER_BIT_DEF = 4;
  localparam int unsigned BAUD_W           = 8;
  localparam int unsigned BIT_IDX_W        = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ser_state_t;

  function automatic logic even_parity(input logic [RESULT_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/alu_bit_timer.sv
// Baud down-counter: one-cycle bit_done every CLKS_PER_BIT enabled cycles,
// restarted from the full period on load.
module alu_bit_timer
  import alu_fifo_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic load,
  output logic bit_done
);

  localparam logic [BAUD_W-1:0] RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

  logic [BAUD_W-1:0] cnt_q;

  // bit_done deliberately ignores load so the FSM may use it to decide a reload.
  assign bit_done = en && (cnt_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load || bit_done) begin
      cnt_q <= RELOAD;
    end else if (en) begin
      cnt_q <= cnt_q - BAUD_W'(1);
    end
  end

endmodule

// File: rtl/alu_result_serializer.sv
// One-entry buffered serializer: start bit, 9 data bits LSB first,
// optional even-parity bit, stop bit; each bit held CLKS_PER_BIT cycles.
module alu_result_serializer
  import alu_fifo_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter bit          PARITY_EN    = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [RESULT_W-1:0]    in_result,
  output logic                   tx_out,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(RESULT_W - 1);

  ser_state_t           state_q, state_d;
  logic                 hold_valid_q, hold_valid_d;
  logic [RESULT_W-1:0]  hold_q, data_q;
  logic [BIT_IDX_W-1:0] bit_q, bit_d, bit_nxt;
  logic                 tx_d, busy_d;
  logic                 accept, unload, frame_done, bit_done;

  assign accept = in_valid && in_ready;

  // Load and unload are exclusive: unload needs hold_valid, which holds in_ready low.
  always_comb begin
    hold_valid_d = hold_valid_q;
    if (unload) begin
      hold_valid_d = 1'b0;
    end else if (accept) begin
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_valid_q <= 1'b0;
      in_ready     <= 1'b1;
      hold_q       <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      in_ready     <= !hold_valid_d;
      if (accept) begin
        hold_q <= in_result;
      end
    end
  end

  alu_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .en      (state_q != ST_IDLE),
    .load    (unload),
    .bit_done(bit_done)
  );

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    tx_d       = tx_out;
    unload     = 1'b0;
    frame_done = 1'b0;
    bit_nxt    = bit_q + BIT_IDX_W'(1);
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (hold_valid_q) begin
          unload  = 1'b1;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = data_q[0];
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_q == LAST_BIT) begin
            if (PARITY_EN) begin
              state_d = ST_PARITY;
              tx_d    = even_parity(data_q);
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_nxt;
            tx_d  = data_q[bit_nxt];
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          frame_done = 1'b1;
          if (hold_valid_q) begin
            unload  = 1'b1;
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      bit_q     <= '0;
      data_q    <= '0;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      tx_out  <= tx_d;
      busy    <= busy_d;
      if (unload) begin
        data_q <= hold_q;
      end
      if (frame_done) begin
        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Three serializer instances (4 clk/bit with parity, 4 clk/bit without,
// 1 clk/bit with parity) checked cycle by cycle against a frame timeline model.
module tb_alu_result_serializer;

  localparam int unsigned NL = 3;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc   = 0;

  int unsigned mode  [NL];
  int unsigned vprob [NL];
  int unsigned dir_n [NL];
  logic [8:0]  dir_w [NL][8];

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int unsigned C  = (g == 2) ? 1 : 4;
    localparam bit          P  = (g != 1);
    localparam int unsigned NB = P ? 12 : 11;

    logic       v, rdy, tx, bsy;
    logic [8:0] d;
    logic [7:0] fc;

    alu_result_serializer #(
      .CLKS_PER_BIT(C),
      .PARITY_EN   (P)
    ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (v),
      .in_ready (rdy),
      .in_result(d),
      .tx_out   (tx),
      .busy     (bsy),
      .frame_cnt(fc)
    );

    // Line level of bit slot k of a frame carrying w.
    function automatic logic fbit(input logic [8:0] w, input int unsigned k);
      if (k == 0) return 1'b0;
      if (k <= 9) return w[k-1];
      if (k == 10 && P) return ^w;
      return 1'b1;
    endfunction

    // Upstream: holds data stable until accepted; garbage on d while idle.
    bit          fire;
    int unsigned sent;
    initial begin
      v = 1'b0; d = '0; sent = 0; fire = 1'b0;
      forever begin
        @(negedge clk);
        fire = v && rdy && reset;
        @(posedge clk);
        #1;
        if (fire) begin v = 1'b0; sent++; end
        if (mode[g] == 0) begin
          v = 1'b0; sent = 0;
        end else if (!v) begin
          if (mode[g] == 1 && sent < dir_n[g]) begin
            v = 1'b1; d = dir_w[g][sent];
          end else if (mode[g] == 2 && $urandom_range(99) < vprob[g]) begin
            v = 1'b1; d = 9'($urandom);
          end
        end
        if (!v) d = 9'($urandom);
      end
    end

    // Timeline model: a word waits in the buffer, then occupies the line for
    // NB*C cycles starting one cycle after acceptance or right after the prior frame.
    bit          hold, act, acc_next, seen_b;
    logic [8:0]  hword, cword, acc_word;
    logic [7:0]  fcnt;
    logic [11:0] rx;
    logic        exp_tx;
    int unsigned cstart, off, frames, bcycles, first_b, last_b;
    initial begin
      hold = 0; act = 0; acc_next = 0; seen_b = 0; fcnt = '0; rx = '0;
      frames = 0; bcycles = 0; first_b = 0; last_b = 0; cstart = 0;
    end
    always @(negedge clk) begin
      if (!reset) begin
        hold = 0; act = 0; acc_next = 0; fcnt = '0;
        frames = 0; bcycles = 0; seen_b = 0; first_b = 0; last_b = 0;
      end else begin
        if (act && cyc == cstart + NB * C) begin
          chk($sformatf("L%0d rx_word", g), 32'(rx[9:1]), 32'(cword));
          chk($sformatf("L%0d rx_par", g), 32'(rx[10]), 32'(P ? ^cword : 1'b1));
          act = 0; fcnt++; frames++;
        end
        if (hold && !act) begin
          act = 1; cword = hword; cstart = cyc; hold = 0;
        end
        if (acc_next) begin
          hold = 1; hword = acc_word;
        end
        if (act) begin
          off = cyc - cstart;
          if (off % C == 0) rx[off / C] = tx;
        end
        if (bsy) begin
          bcycles++;
          if (!seen_b) first_b = cyc;
          seen_b = 1; last_b = cyc;
        end
      end
      exp_tx = act ? fbit(cword, (cyc - cstart) / C) : 1'b1;
      chk($sformatf("L%0d tx_out", g), 32'(tx), 32'(exp_tx));
      chk($sformatf("L%0d busy", g), 32'(bsy), 32'(act));
      chk($sformatf("L%0d in_ready", g), 32'(rdy), 32'(!hold));
      chk($sformatf("L%0d frame_cnt", g), 32'(fc), 32'(fcnt));
      acc_next = reset && v && !hold;
      acc_word = d;
    end
  end

  task automatic assert_reset();
    for (int i = 0; i < NL; i++) mode[i] = 0;
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NL; i++) begin
      mode[i] = 0; vprob[i] = 0; dir_n[i] = 0;
    end
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst tx_out", 32'(lane[0].tx), 32'd1);
    chk("rst busy", 32'(lane[0].bsy), 32'd0);
    chk("rst in_ready", 32'(lane[0].rdy), 32'd1);
    chk("rst frame_cnt", 32'(lane[0].fc), 32'd0);

    // Single frames: 0x006 with parity, 0x1FF without, 0x1FF at one clock per bit.
    dir_w[0][0] = 9'h006; dir_w[1][0] = 9'h1FF; dir_w[2][0] = 9'h1FF;
    for (int i = 0; i < NL; i++) begin dir_n[i] = 1; mode[i] = 1; end
    release_reset();
    repeat (70) @(posedge clk);
    #1;
    chk("single L0 frames", lane[0].frames, 32'd1);
    chk("single L0 busy_cycles", lane[0].bcycles, 32'd48);
    chk("single L0 frame_cnt", 32'(lane[0].fc), 32'd1);
    chk("single L1 busy_cycles", lane[1].bcycles, 32'd44);
    chk("single L2 busy_cycles", lane[2].bcycles, 32'd12);

    // Back-to-back words with in_valid held high.
    assert_reset();
    for (int i = 0; i < NL; i++) begin
      dir_w[i][0] = 9'h006; dir_w[i][1] = 9'h004; dir_w[i][2] = 9'h008;
      dir_n[i] = 3; mode[i] = 1;
    end
    release_reset();
    repeat (160) @(posedge clk);
    #1;
    chk("b2b L0 frame_cnt", 32'(lane[0].fc), 32'd3);
    chk("b2b L0 busy_cycles", lane[0].bcycles, 32'd144);
    chk("b2b L0 no_gap", lane[0].last_b - lane[0].first_b + 1, lane[0].bcycles);
    chk("b2b L1 busy_cycles", lane[1].bcycles, 32'd132);
    chk("b2b L2 frame_cnt", 32'(lane[2].fc), 32'd3);

    // Reset in the middle of a frame carrying 0x0A5.
    assert_reset();
    dir_w[0][0] = 9'h0A5; dir_n[0] = 1; mode[0] = 1;
    release_reset();
    repeat (20) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst tx_out", 32'(lane[0].tx), 32'd1);
    chk("midrst busy", 32'(lane[0].bsy), 32'd0);
    chk("midrst in_ready", 32'(lane[0].rdy), 32'd1);
    chk("midrst frame_cnt", 32'(lane[0].fc), 32'd0);
    assert_reset();

    // Random traffic until the fast lane wraps its frame counter.
    vprob[0] = 40; vprob[1] = 60; vprob[2] = 95;
    for (int i = 0; i < NL; i++) mode[i] = 2;
    release_reset();
    for (int k = 0; k < 8000 && lane[2].frames < 260; k++) @(posedge clk);
    for (int i = 0; i < NL; i++) mode[i] = 0;
    repeat (150) @(posedge clk);
    #1;
    chk("rand L2 wrap_reached", 32'(lane[2].frames >= 260), 32'd1);
    chk("rand L2 frame_cnt", 32'(lane[2].fc), lane[2].frames % 256);
    chk("rand L0 frame_cnt", 32'(lane[0].fc), lane[0].frames % 256);
    chk("rand L1 idle busy", 32'(lane[1].bsy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
